serial_rx: RTL and testbench
============================

Name: serial_rx

Overview:
- 8N1 asynchronous serial receiver, LSB first, idle-high line.
- Pairs with the existing serial transmitter: same bit period, same framing.
- Converts the incoming `rx` pin to a byte with a one-cycle `new_data` strobe for the board control logic.
- Adds start-glitch rejection, stop-bit framing check and break/line-low recovery.

Parameters:
- CLK_PER_BIT, 2604, clock cycles per serial bit; must be >= 4.
- CTR_SIZE, $clog2(CLK_PER_BIT), width of the bit-period counter; derived, not overridden.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- rx  input  1  serial line, asynchronous to clk, idle high.
- data  output  8  last correctly framed byte; held until the next good frame.
- new_data  output  1  one-cycle pulse: `data` updated this cycle.
- frame_err  output  1  one-cycle pulse: stop bit sampled low, byte discarded.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Clock and reset (already decided): one clock, `clk`; reset `rst` is asynchronous and active-low.
- Reset values: data=8'h00, new_data=0, frame_err=0, busy=1. Synchronizer flops=1, counters=0, state=WAIT_HIGH.
- Input synchronisation: `rx` passes through two flops to give `rx_s`. All decisions use `rx_s`; there is 2 cycles of input latency.
- HALF = CLK_PER_BIT/2 (integer division).
- Counter `ctr` is CTR_SIZE bits, increments every cycle in START/DATA/STOP, and clears at each sample point.

State machine, states IDLE, START, DATA, STOP, WAIT_HIGH:
- WAIT_HIGH: busy=1; go to IDLE on the first cycle `rx_s`=1. This prevents false starts after reset mid-frame or a break.
- IDLE: busy=0.
  - `rx_s`=0 at edge E0 -> START, ctr=0, bit_ctr=0.
- START: at ctr==HALF-1, sample `rx_s` (edge E0+HALF).
  - 0 -> DATA, ctr=0.
  - 1 -> IDLE as a glitch; no pulse.
- DATA: at ctr==CLK_PER_BIT-1, sample `rx_s` into shift[bit_ctr], then bit_ctr++.
  - Bit i is sampled at edge E0+HALF+(i+1)*CLK_PER_BIT.
  - After bit 7 -> STOP, ctr=0.
  - bit_ctr is 3 bits; its wrap 7->0 coincides with leaving DATA.
- STOP: at ctr==CLK_PER_BIT-1 (edge E0+HALF+9*CLK_PER_BIT), sample `rx_s`.
  - 1: data<=shift, new_data=1 for exactly the next cycle, -> IDLE.
  - 0: frame_err=1 for exactly the next cycle, data unchanged, -> WAIT_HIGH.
- Back-to-back frames: IDLE is entered mid stop bit, so a start edge immediately after the stop bit is detected with no lost cycles.
- new_data and frame_err are mutually exclusive and registered; they are never both high.
- Reset asserted mid-frame: immediate return to reset values. After release, no byte is produced until `rx_s` has been seen high.
- rx transitions between sample points are ignored; there is no oversampling or majority vote.

Decomposition:
- Shared package `serial_pkg`: STATE_SIZE and the state encodings (IDLE, START, DATA, STOP, WAIT_HIGH as 3-bit constants). Also the 8N1 frame constants DATA_BITS=8 and STOP_BITS=1, reused by serial_tx.
- One sub-module is natural: `sync_2ff`, a two-flop synchronizer with async active-low reset and a reset value parameter (here 1). Reusable for other pin inputs.
- Everything else stays in serial_rx.

Test Plan (sim with CLK_PER_BIT=16, HALF=8, ideal bit timing from bench):
- Send 0x55 after reset + 20 idle cycles -> exactly one new_data pulse with data=0x55. The pulse lands HALF+9*16+1 cycles after the edge where `rx_s` first reads 0. busy high from start detect to the pulse, frame_err never high.
- Send 0xA3 then 0x0F with zero idle between stop and next start -> two new_data pulses, data=0xA3 then 0x0F, 160 cycles apart.
- Drive rx low for 4 cycles then high -> return to IDLE at E0+8 with busy low. No new_data or frame_err, data unchanged.
- Send 0x3C with stop bit held low, keep rx low 50 cycles, then high, then send 0x81:
  - one frame_err pulse; data keeps its previous value; busy stays high until rx returns high;
  - 0x81 is then received with new_data.
- Assert rst low during data bit 3 of 0xFF, release while rx still low -> outputs at reset values. No new_data for the remainder of that frame; the next full frame 0x12 is received correctly.
- Sweep all 256 byte values back-to-back with a ±3% bit-period skew from the bench -> all received in order with no frame_err.

Source files
------------

// File: rtl/serial_pkg.sv
//------------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the 8N1 serial receiver and transmitter.
//   STATE_SIZE    : width of the receiver state register
//   state_e       : receiver FSM state encodings
//   DATA_BITS     : data bits per frame (8N1)
//   STOP_BITS     : stop bits per frame (8N1)
//   BIT_CTR_SIZE  : width of a counter indexing the data bits
//------------------------------------------------------------------------------
`timescale 1ns/1ps
package serial_pkg;

  localparam int STATE_SIZE = 3;

  typedef enum logic [STATE_SIZE-1:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_e;

  localparam int DATA_BITS    = 8;
  localparam int STOP_BITS    = 1;
  localparam int BIT_CTR_SIZE = $clog2(DATA_BITS);

endpackage

// File: rtl/serial_rx_if.sv
//------------------------------------------------------------------------------
// serial_rx_if
// Bundles the serial line input and the received-byte outputs.
//   rx        : serial line, idle high (driven by the line side)
//   data      : last correctly framed byte
//   new_data  : one-cycle strobe, data updated this cycle
//   frame_err : one-cycle strobe, stop bit was low and the byte was dropped
//   busy      : receiver is not idle
//   state     : receiver FSM state, for observation only
//
// Handshake: new_data is a valid-only strobe with no ready. The receiver
// cannot be stalled, so a consumer must capture data in the cycle new_data
// is high; data then stays stable until the next good frame.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
interface serial_rx_if;
  import serial_pkg::*;

  logic                  rx;
  logic [DATA_BITS-1:0]  data;
  logic                  new_data;
  logic                  frame_err;
  logic                  busy;
  logic [STATE_SIZE-1:0] state;

  // Receiver side
  modport slave (
    input  rx,
    output data, new_data, frame_err, busy, state
  );

  // Line / consumer side
  modport master (
    output rx,
    input  data, new_data, frame_err, busy, state
  );
endinterface

// File: rtl/sync_2ff.sv
//------------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous input.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, both flops load RST_VAL
//   d_i    : asynchronous input
//   q_o    : synchronized output, two cycles of latency
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/serial_rx.sv
//------------------------------------------------------------------------------
// serial_rx
// 8N1 asynchronous serial receiver, LSB first, idle-high line.
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : serial_rx_if.slave (rx in; data, new_data, frame_err, busy, state out)
// CLK_PER_BIT is the bit period in clock cycles and must be at least 4.
// A start edge is confirmed at mid start bit, each later bit is sampled one
// full bit period after the previous sample, so samples sit mid-bit.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module serial_rx
  import serial_pkg::*;
#(
  parameter int  CLK_PER_BIT = 2604,
  localparam int CTR_SIZE    = $clog2(CLK_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  serial_rx_if.slave bus
);

  localparam int                    HALF     = CLK_PER_BIT / 2;
  localparam logic [CTR_SIZE-1:0]   HALF_M1  = CTR_SIZE'(HALF - 1);
  localparam logic [CTR_SIZE-1:0]   BIT_LAST = CTR_SIZE'(CLK_PER_BIT - 1);
  localparam logic [BIT_CTR_SIZE-1:0] LAST_BIT = BIT_CTR_SIZE'(DATA_BITS - 1);

  logic rx_s;

  state_e                  state_q,     state_d;
  logic [CTR_SIZE-1:0]     ctr_q,       ctr_d;
  logic [BIT_CTR_SIZE-1:0] bit_ctr_q,   bit_ctr_d;
  logic [DATA_BITS-1:0]    shift_q,     shift_d;
  logic [DATA_BITS-1:0]    data_q,      data_d;
  logic                    new_data_q,  new_data_d;
  logic                    frame_err_q, frame_err_d;

  // Synchronizer resets high so a held-low line is not mistaken for a start.
  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (bus.rx),
    .q_o    (rx_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= WAIT_HIGH;
      ctr_q       <= '0;
      bit_ctr_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      new_data_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      bit_ctr_q   <= bit_ctr_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      new_data_q  <= new_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ctr_d       = ctr_q;
    bit_ctr_d   = bit_ctr_q;
    shift_d     = shift_q;
    data_d      = data_q;
    new_data_d  = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      // Only arm once the line has been seen idle, so reset or a break in the
      // middle of a frame cannot produce a false start.
      WAIT_HIGH: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      IDLE: begin
        if (!rx_s) begin
          state_d   = START;
          ctr_d     = '0;
          bit_ctr_d = '0;
        end
      end

      // Re-check mid start bit; a line already back high was a glitch.
      START: begin
        if (ctr_q == HALF_M1) begin
          ctr_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          ctr_d = ctr_q + CTR_SIZE'(1);
        end
      end

      DATA: begin
        if (ctr_q == BIT_LAST) begin
          ctr_d              = '0;
          shift_d[bit_ctr_q] = rx_s;
          bit_ctr_d          = bit_ctr_q + BIT_CTR_SIZE'(1);
          if (bit_ctr_q == LAST_BIT) begin
            state_d = STOP;
          end
        end else begin
          ctr_d = ctr_q + CTR_SIZE'(1);
        end
      end

      // Leaving at mid stop bit lets a back-to-back start edge be caught
      // without losing any cycles.
      STOP: begin
        if (ctr_q == BIT_LAST) begin
          ctr_d = '0;
          if (rx_s) begin
            data_d     = shift_q;
            new_data_d = 1'b1;
            state_d    = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HIGH;
          end
        end else begin
          ctr_d = ctr_q + CTR_SIZE'(1);
        end
      end

      default: begin
        state_d = WAIT_HIGH;
      end
    endcase
  end

  assign bus.data      = data_q;
  assign bus.new_data  = new_data_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.state     = state_q;

endmodule

// File: tb/tb_serial_rx.sv
`timescale 1ns/1ps
module tb_serial_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  // Cycles from driving the start edge to seeing new_data/frame_err:
  // 2 synchronizer flops, 1 edge detect, half a bit, then 9 full bits.
  localparam int PULSE_LAT = 3 + HALF + 9 * CPB;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_rx_if u_if ();

  serial_rx #(
    .CLK_PER_BIT (CPB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  // ---------------- counters / scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_data = 8'h00;

  logic [7:0] got_q[$];
  int         got_cyc_q[$];
  int         fe_cnt = 0;
  int         fe_cyc = 0;
  bit         both_seen = 1'b0;

  // Monitor: records every strobe the receiver emits.
  always @(negedge clk) begin
    if (u_if.new_data === 1'b1) begin
      got_q.push_back(u_if.data);
      got_cyc_q.push_back(cyc);
    end
    if (u_if.frame_err === 1'b1) begin
      fe_cnt = fe_cnt + 1;
      fe_cyc = cyc;
    end
    if (u_if.new_data === 1'b1 && u_if.frame_err === 1'b1) both_seen = 1'b1;
  end

  // ---------------- driver tasks ----------------
  // Sends one frame on clock-aligned bit boundaries; must be entered at a
  // negedge and returns at the negedge where the next start bit may begin.
  task automatic send_byte(input logic [7:0] b, input logic stop_val, output int c0);
    logic [9:0] frame;
    frame = {stop_val, b, 1'b0};
    c0 = cyc;
    for (int i = 0; i < 10; i++) begin
      u_if.rx = frame[i];
      repeat (CPB) @(negedge clk);
    end
    if (stop_val) begin
      exp_q.push_back(b);
      exp_data = b;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst     = 1'b0;
    u_if.rx = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (u_if.data !== 8'h00) begin
      miscompares++; $display("FAIL reset_data got %h exp 00", u_if.data);
    end
    vectors++;
    if (u_if.new_data !== 1'b0 || u_if.frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_strobes got nd=%b fe=%b exp 0 0", u_if.new_data, u_if.frame_err);
    end
    vectors++;
    if (u_if.busy !== 1'b1) begin
      miscompares++; $display("FAIL reset_busy got %b exp 1", u_if.busy);
    end
    rst = 1'b1;
    repeat (20) @(negedge clk);
    vectors++;
    if (u_if.busy !== 1'b0) begin
      miscompares++; $display("FAIL idle_after_reset_busy got %b exp 0", u_if.busy);
    end
  endtask

  task automatic test_single();
    int c0, g0, e0, fe0;
    g0 = got_q.size(); e0 = exp_q.size(); fe0 = fe_cnt;
    fork
      send_byte(8'h55, 1'b1, c0);
      begin
        repeat (2) @(negedge clk);
        vectors++;
        if (u_if.busy !== 1'b0) begin
          miscompares++; $display("FAIL single_busy_pre_detect got %b exp 0", u_if.busy);
        end
        @(negedge clk);
        vectors++;
        if (u_if.busy !== 1'b1) begin
          miscompares++; $display("FAIL single_busy_detect got %b exp 1", u_if.busy);
        end
        repeat (PULSE_LAT - 4) @(negedge clk);
        vectors++;
        if (u_if.busy !== 1'b1) begin
          miscompares++; $display("FAIL single_busy_before_pulse got %b exp 1", u_if.busy);
        end
      end
    join
    repeat (5) @(negedge clk);
    vectors++;
    if (got_q.size() !== g0 + 1) begin
      miscompares++; $display("FAIL single_count got %0d exp %0d", got_q.size() - g0, 1);
    end else begin
      vectors++;
      if (got_q[g0] !== exp_q[e0]) begin
        miscompares++; $display("FAIL single_data got %h exp %h", got_q[g0], exp_q[e0]);
      end
      vectors++;
      if (got_cyc_q[g0] !== c0 + PULSE_LAT) begin
        miscompares++;
        $display("FAIL single_latency got %0d exp %0d", got_cyc_q[g0] - c0, PULSE_LAT);
      end
    end
    vectors++;
    if (fe_cnt !== fe0 || u_if.data !== exp_data) begin
      miscompares++;
      $display("FAIL single_hold got fe=%0d data=%h exp fe=%0d data=%h", fe_cnt - fe0, u_if.data, 0, exp_data);
    end
  endtask

  task automatic test_back_to_back();
    int c0, c1, g0, e0;
    g0 = got_q.size(); e0 = exp_q.size();
    send_byte(8'hA3, 1'b1, c0);
    send_byte(8'h0F, 1'b1, c1);
    repeat (10) @(negedge clk);
    vectors++;
    if (got_q.size() !== g0 + 2) begin
      miscompares++; $display("FAIL b2b_count got %0d exp 2", got_q.size() - g0);
    end else begin
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (got_q[g0 + i] !== exp_q[e0 + i]) begin
          miscompares++; $display("FAIL b2b_data[%0d] got %h exp %h", i, got_q[g0 + i], exp_q[e0 + i]);
        end
      end
      vectors++;
      if (got_cyc_q[g0 + 1] - got_cyc_q[g0] !== c1 - c0) begin
        miscompares++;
        $display("FAIL b2b_spacing got %0d exp %0d", got_cyc_q[g0 + 1] - got_cyc_q[g0], c1 - c0);
      end
    end
  endtask

  task automatic test_glitch();
    int c0, g0, fe0;
    g0 = got_q.size(); fe0 = fe_cnt;
    c0 = cyc;
    u_if.rx = 1'b0;
    repeat (4) @(negedge clk);
    u_if.rx = 1'b1;
    repeat (3 + HALF - 1 - 4) @(negedge clk);
    vectors++;
    if (u_if.busy !== 1'b1) begin
      miscompares++; $display("FAIL glitch_busy_in_start got %b exp 1 at +%0d", u_if.busy, cyc - c0);
    end
    @(negedge clk);
    vectors++;
    if (u_if.busy !== 1'b0) begin
      miscompares++; $display("FAIL glitch_back_idle got %b exp 0 at +%0d", u_if.busy, cyc - c0);
    end
    repeat (30) @(negedge clk);
    vectors++;
    if (got_q.size() !== g0 || fe_cnt !== fe0 || u_if.data !== exp_data) begin
      miscompares++;
      $display("FAIL glitch_no_output got nd=%0d fe=%0d data=%h exp 0 0 %h",
               got_q.size() - g0, fe_cnt - fe0, u_if.data, exp_data);
    end
  endtask

  task automatic test_frame_error();
    int c0, c1, g0, e0, fe0;
    g0 = got_q.size(); fe0 = fe_cnt;
    send_byte(8'h3C, 1'b0, c0);
    repeat (50) @(negedge clk);
    vectors++;
    if (fe_cnt !== fe0 + 1) begin
      miscompares++; $display("FAIL ferr_count got %0d exp 1", fe_cnt - fe0);
    end
    vectors++;
    if (fe_cyc !== c0 + PULSE_LAT) begin
      miscompares++; $display("FAIL ferr_latency got %0d exp %0d", fe_cyc - c0, PULSE_LAT);
    end
    vectors++;
    if (got_q.size() !== g0 || u_if.data !== exp_data) begin
      miscompares++;
      $display("FAIL ferr_data_kept got nd=%0d data=%h exp 0 %h", got_q.size() - g0, u_if.data, exp_data);
    end
    vectors++;
    if (u_if.busy !== 1'b1) begin
      miscompares++; $display("FAIL ferr_busy_line_low got %b exp 1", u_if.busy);
    end
    u_if.rx = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (u_if.busy !== 1'b1) begin
      miscompares++; $display("FAIL ferr_busy_sync got %b exp 1", u_if.busy);
    end
    @(negedge clk);
    vectors++;
    if (u_if.busy !== 1'b0) begin
      miscompares++; $display("FAIL ferr_recover_idle got %b exp 0", u_if.busy);
    end
    repeat (10) @(negedge clk);
    g0 = got_q.size(); e0 = exp_q.size();
    send_byte(8'h81, 1'b1, c1);
    repeat (5) @(negedge clk);
    vectors++;
    if (got_q.size() !== g0 + 1) begin
      miscompares++; $display("FAIL ferr_next_count got %0d exp 1", got_q.size() - g0);
    end else begin
      vectors++;
      if (got_q[g0] !== exp_q[e0]) begin
        miscompares++; $display("FAIL ferr_next_data got %h exp %h", got_q[g0], exp_q[e0]);
      end
    end
  endtask

  task automatic test_mid_frame_reset();
    int c1, g0, e0, fe0;
    logic [9:0] frame;
    g0 = got_q.size(); fe0 = fe_cnt;
    frame = {1'b1, 8'hFF, 1'b0};
    // Start bit and data bits 0..2, then part of bit 3.
    for (int i = 0; i < 4; i++) begin
      u_if.rx = frame[i];
      repeat (CPB) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    rst     = 1'b0;
    u_if.rx = 1'b0;
    exp_data = 8'h00;
    @(negedge clk);
    vectors++;
    if (u_if.data !== 8'h00 || u_if.new_data !== 1'b0 || u_if.frame_err !== 1'b0 || u_if.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_values got data=%h nd=%b fe=%b busy=%b exp 00 0 0 1",
               u_if.data, u_if.new_data, u_if.frame_err, u_if.busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    vectors++;
    if (u_if.busy !== 1'b1) begin
      miscompares++; $display("FAIL midrst_wait_high_busy got %b exp 1", u_if.busy);
    end
    // Remainder of the frame: bits 4..7 and the stop bit, all high.
    u_if.rx = 1'b1;
    repeat (5 * CPB + 20) @(negedge clk);
    vectors++;
    if (got_q.size() !== g0 || fe_cnt !== fe0 || u_if.data !== exp_data || u_if.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_quiet got nd=%0d fe=%0d data=%h busy=%b exp 0 0 %h 0",
               got_q.size() - g0, fe_cnt - fe0, u_if.data, u_if.busy, exp_data);
    end
    g0 = got_q.size(); e0 = exp_q.size();
    send_byte(8'h12, 1'b1, c1);
    repeat (5) @(negedge clk);
    vectors++;
    if (got_q.size() !== g0 + 1) begin
      miscompares++; $display("FAIL midrst_next_count got %0d exp 1", got_q.size() - g0);
    end else begin
      vectors++;
      if (got_q[g0] !== exp_q[e0]) begin
        miscompares++; $display("FAIL midrst_next_data got %h exp %h", got_q[g0], exp_q[e0]);
      end
    end
  endtask

  // All 256 values back-to-back, each frame with its own random bit period
  // within +/-3% of nominal, not aligned to the clock.
  task automatic test_sweep_skew();
    int       g0, e0, fe0, skew;
    realtime  bit_t;
    logic [9:0] frame;
    g0 = got_q.size(); e0 = exp_q.size(); fe0 = fe_cnt;
    for (int b = 0; b < 256; b++) begin
      skew  = int'($urandom_range(60)) - 30;
      bit_t = 10.0 * CPB * (1000.0 + skew) / 1000.0;
      frame = {1'b1, 8'(b), 1'b0};
      for (int i = 0; i < 10; i++) begin
        u_if.rx = frame[i];
        #(bit_t);
      end
      exp_q.push_back(8'(b));
      exp_data = 8'(b);
    end
    u_if.rx = 1'b1;
    @(negedge clk);
    repeat (20) @(negedge clk);
    vectors++;
    if (got_q.size() !== g0 + 256) begin
      miscompares++; $display("FAIL sweep_count got %0d exp 256", got_q.size() - g0);
    end else begin
      for (int i = 0; i < 256; i++) begin
        vectors++;
        if (got_q[g0 + i] !== exp_q[e0 + i]) begin
          miscompares++; $display("FAIL sweep_data[%0d] got %h exp %h", i, got_q[g0 + i], exp_q[e0 + i]);
        end
      end
    end
    vectors++;
    if (fe_cnt !== fe0) begin
      miscompares++; $display("FAIL sweep_frame_err got %0d exp 0", fe_cnt - fe0);
    end
    vectors++;
    if (u_if.data !== exp_data) begin
      miscompares++; $display("FAIL sweep_last_data got %h exp %h", u_if.data, exp_data);
    end
    vectors++;
    if (both_seen !== 1'b0) begin
      miscompares++; $display("FAIL strobes_exclusive got both=%b exp 0", both_seen);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    u_if.rx = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    repeat (10) @(negedge clk);
    test_back_to_back();
    repeat (10) @(negedge clk);
    test_glitch();
    test_frame_error();
    repeat (10) @(negedge clk);
    test_mid_frame_reset();
    repeat (10) @(negedge clk);
    test_sweep_skew();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
